delay_line_ctrl: RTL and testbench
==================================

Name: delay_line_ctrl

Overview:
- Runtime-programmable delay-line controller that sequences an external simple-dual-port BRAM (sync_bram_sdp, 1-cycle read latency, DO_REG=0) as a ring buffer.
- Delays a sample stream plus its valid bit by exactly cfg_delay cycles.
- Handles reconfiguration by refilling the buffer and masks stale BRAM contents.
- Sits between pixel/argument pipelines where the required alignment delay is only known at run time.

Parameters:
- WIDTH, 16, payload data width.
- AW, 9, BRAM address width; DEPTH = 2**AW.
- INIT_DELAY, 0, delay applied after reset. 0 means start in IDLE. Must be 0 or within 2..DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_vld  in  1  new delay request
- cfg_rdy  out  1  request can be accepted
- cfg_delay  in  AW+1  requested delay in cycles, legal 2..DEPTH
- cfg_err  out  1  one-cycle pulse: request accepted but out of range
- cur_delay  out  AW+1  delay currently in force
- primed  out  1  high in RUN
- in_vld  in  1  input sample valid
- in_data  in  WIDTH  input sample
- out_vld  out  1  delayed in_vld
- out_data  out  WIDTH  delayed in_data
- wren  out  1  BRAM write enable
- wraddr  out  AW  BRAM write address
- wrdata  out  WIDTH+1  {in_vld, in_data}
- rden  out  1  BRAM read enable
- rdaddr  out  AW  BRAM read address
- rddata  in  WIDTH+1  BRAM read data, valid 1 cycle after rden

Behaviour:
- **States:** IDLE, FILL, RUN.
- **Reset values:** state = FILL if INIT_DELAY≠0, else IDLE. wptr=0, fill counter cnt=0, cur_delay=INIT_DELAY, rd_ph=0, cfg_err=0. Outputs: out_vld=0, rden=0, cfg_rdy=1 (IDLE) or 0 (FILL).
- **Write path:**
  - wren = (state≠IDLE); wraddr = wptr.
  - wptr increments mod DEPTH on every wren cycle and wraps 511→0 seamlessly.
  - wrdata = {in_vld, in_data}, written every cycle, valid or not.
- **Read path:**
  - rden = (state==RUN); rdaddr = (wptr − (cur_delay−1)) mod DEPTH.
  - rd_ph is rden registered.
  - out_vld = rd_ph & rddata[WIDTH]; out_data = rddata[WIDTH-1:0] (combinational pass-through).
- **Handshake:**
  - cfg_rdy = (state≠FILL); a request is accepted on cfg_vld & cfg_rdy.
  - Accepted with 2 ≤ cfg_delay ≤ DEPTH: latch cur_delay, cnt←0, state←FILL on the next cycle. wptr is not reset.
  - Accepted out of range (0, 1, >DEPTH): cfg_err pulses the next cycle; state and cur_delay are unchanged.
- **FILL:**
  - The first FILL cycle is T0, which is the first write.
  - cnt increments each cycle; when cnt==cur_delay−2, state←RUN.
  - The first rden is therefore at T0+D−1, and the first out_vld is possible at T0+D.
- **Latency:** sample written at cycle t appears on out_data/out_vld at t+D exactly.
- **Reconfig from RUN accepted at cycle A:**
  - Cycle A+1 still outputs old-delay data.
  - out_vld=0 from A+2 through A+D.
  - New-delay output from A+1+D. Stale data is never flagged valid.
- **Collision:** D=DEPTH reads address wptr+1, so there is never a read/write collision. Delays below 2 are illegal.
- **Reset mid-operation:** next cycle is the reset state. In-flight data is discarded; rd_ph=0, so out_vld=0.
- cur_delay and primed are registered state. primed = (state==RUN).

Test Plan:
1. INIT_DELAY=0, reset, then cfg_delay=5 accepted at cycle A, in_data ramp 0,1,2… with in_vld=1 from A+1 -> out_vld first high at A+6, out_data=0. out_data tracks the ramp with lag 5; cfg_rdy low A+1..A+4.
2. cfg_delay=2, then 512, each run past 1100 cycles -> lag exactly 2 / 512. No glitch across wptr wrap 511→0; rdaddr at D=512 equals wptr+1.
3. In RUN with D=8, requests 0, 1, 513 -> cfg_err pulses once each. cur_delay stays 8; out_vld stream uninterrupted.
4. RUN D=10, cfg_delay=4 accepted at A -> out_vld=1 at A+1 (old data), 0 over A+2..A+4, resumes A+5 with data written at A+1.
5. D=3, in_vld pattern 1,0,1,1,0 with data 0xA..0xE -> out_vld 1,0,1,1,0 three cycles later, out_data 0xA,–,0xC,0xD,–.
6. rst pulsed mid-RUN with D=6 -> next cycle state IDLE, wren=rden=out_vld=0, cfg_rdy=1, wptr=0, cur_delay=INIT_DELAY.

Source files
------------

// File: rtl/delay_line_ctrl_if.sv
// Config, sample-stream and BRAM-port signals of the delay-line controller.
// master = controller side, slave = the surrounding pipeline/BRAM side.
interface delay_line_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 9
);
  logic              cfg_vld;
  logic              cfg_rdy;
  logic [AW:0]       cfg_delay;
  logic              cfg_err;
  logic [AW:0]       cur_delay;
  logic              primed;
  logic              in_vld;
  logic [WIDTH-1:0]  in_data;
  logic              out_vld;
  logic [WIDTH-1:0]  out_data;
  logic              wren;
  logic [AW-1:0]     wraddr;
  logic [WIDTH:0]    wrdata;
  logic              rden;
  logic [AW-1:0]     rdaddr;
  logic [WIDTH:0]    rddata;

  modport master (
    input  cfg_vld, cfg_delay, in_vld, in_data, rddata,
    output cfg_rdy, cfg_err, cur_delay, primed, out_vld, out_data,
           wren, wraddr, wrdata, rden, rdaddr
  );

  modport slave (
    output cfg_vld, cfg_delay, in_vld, in_data, rddata,
    input  cfg_rdy, cfg_err, cur_delay, primed, out_vld, out_data,
           wren, wraddr, wrdata, rden, rdaddr
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Ring-buffer delay line over an external 1-cycle-latency SDP BRAM: delays {in_vld,in_data} by exactly cur_delay cycles.
// No stream backpressure; cfg_rdy drops while the buffer refills after a delay change.
module delay_line_ctrl #(
  parameter int WIDTH      = 16,
  parameter int AW         = 9,
  parameter int INIT_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  delay_line_ctrl_if.master bus
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_V   = (AW+1)'(1);
  localparam logic [AW:0] TWO_V   = (AW+1)'(2);
  localparam logic [AW:0] INIT_V  = (AW+1)'(INIT_DELAY);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  localparam state_t RST_STATE = (INIT_DELAY != 0) ? FILL : IDLE;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr;
  logic [AW:0]   cnt, cnt_nxt;
  logic [AW:0]   cur_delay, cur_delay_nxt;
  logic          rd_ph;
  logic          cfg_err_q;

  logic accept;
  logic legal;
  logic fill_done;
  logic wr_en;
  logic rd_en;

  assign accept    = bus.cfg_vld && (state != FILL);
  assign legal     = (bus.cfg_delay >= TWO_V) && (bus.cfg_delay <= DEPTH_V);
  assign fill_done = (cnt == (cur_delay - TWO_V));
  assign wr_en     = (state != IDLE);
  assign rd_en     = (state == RUN);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cur_delay_nxt = cur_delay;
    case (state)
      IDLE, RUN: begin
        if (accept && legal) begin
          state_nxt     = FILL;
          cnt_nxt       = '0;
          cur_delay_nxt = bus.cfg_delay;
        end
      end
      FILL: begin
        // D-1 fill cycles so the first read lands on the first written sample
        cnt_nxt = cnt + ONE_V;
        if (fill_done) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      wptr      <= '0;
      cnt       <= '0;
      cur_delay <= INIT_V;
      rd_ph     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cur_delay <= cur_delay_nxt;
      rd_ph     <= rd_en;
      cfg_err_q <= accept && !legal;
      if (wr_en) begin
        wptr <= wptr + AW'(1);
      end
    end
  end

  assign bus.wren      = wr_en;
  assign bus.wraddr    = wptr;
  assign bus.wrdata    = {bus.in_vld, bus.in_data};
  assign bus.rden      = rd_en;
  // At D=DEPTH this is wptr+1, so a read never targets the slot being written
  assign bus.rdaddr    = wptr - AW'(cur_delay - ONE_V);

  // Valid bit is gated by read phase so stale BRAM contents are never flagged
  assign bus.out_vld   = rd_ph && bus.rddata[WIDTH];
  assign bus.out_data  = bus.rddata[WIDTH-1:0];

  assign bus.cfg_rdy   = (state != FILL);
  assign bus.cfg_err   = cfg_err_q;
  assign bus.cur_delay = cur_delay;
  assign bus.primed    = (state == RUN);
endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl with a behavioural 1-cycle-latency SDP BRAM.
module tb_delay_line_ctrl;
  localparam int WIDTH = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delay_line_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  delay_line_ctrl #(.WIDTH(WIDTH), .AW(AW), .INIT_DELAY(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [WIDTH:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.wren) mem[bus.wraddr] <= bus.wrdata;
    if (bus.rden) bus.rddata <= mem[bus.rdaddr];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] ramp;
  logic        hist_vld [8192];
  logic [15:0] hist_dat [8192];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs applied in interval cyc are written at the following edge.
  task automatic drive(input logic v, input logic [15:0] d);
    bus.in_vld  = v;
    bus.in_data = d;
    hist_vld[cyc] = v;
    hist_dat[cyc] = d;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_ramp();
    drive(1'b1, ramp);
    ramp = ramp + 16'd1;
  endtask

  function automatic int stream_bad(input int lag);
    logic ev;
    ev = hist_vld[cyc-lag];
    if (bus.out_vld !== ev) return 1;
    if (ev && (bus.out_data !== hist_dat[cyc-lag])) return 1;
    return 0;
  endfunction

  function automatic int exp_vld(input int lag);
    return int'(hist_vld[cyc-lag]);
  endfunction

  task automatic run_stream(input string tag, input int lag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      bad += stream_bad(lag);
      drive_ramp();
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  // Accept newd from RUN, then track old-data cycle, blanking window and new lag.
  task automatic reconfig_run(input string tag, input int newd, input int oldd, input int n);
    int bad = 0;
    int nv = 0;
    int env = 0;
    int abad = 0;
    bus.cfg_vld   = 1'b1;
    bus.cfg_delay = 10'(newd);
    drive_ramp();
    bus.cfg_vld   = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        bad += stream_bad(oldd);
        env += exp_vld(oldd);
      end else if (i < newd) begin
        bad += int'(bus.out_vld !== 1'b0);
      end else begin
        bad += stream_bad(newd);
        env += exp_vld(newd);
      end
      if (newd == DEPTH && i >= newd - 1)
        abad += int'(bus.rdaddr !== AW'(bus.wraddr + 9'd1));
      nv += int'(bus.out_vld);
      drive_ramp();
    end
    chk({tag, "_stream"}, 32'(bad), 32'd0);
    chk({tag, "_nvld"}, 32'(nv), 32'(env));
    chk({tag, "_rdaddr"}, 32'(abad), 32'd0);
    chk({tag, "_cur"}, 32'(bus.cur_delay), 32'(newd));
  endtask

  initial begin
    int bad;
    int badv [3];
    logic       pat_v [5];
    logic [15:0] pat_d [5];
    badv  = '{0, 1, 513};
    pat_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    pat_d = '{16'hA, 16'hB, 16'hC, 16'hD, 16'hE};

    rst = 1'b1;
    bus.cfg_vld = 1'b0;
    bus.cfg_delay = '0;
    bus.in_vld = 1'b0;
    bus.in_data = '0;
    ramp = 16'd0;
    drive(1'b0, 16'd0);
    drive(1'b0, 16'd0);
    rst = 1'b0;

    chk("rst_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    chk("rst_primed", 32'(bus.primed), 32'd0);
    chk("rst_wren", 32'(bus.wren), 32'd0);
    chk("rst_rden", 32'(bus.rden), 32'd0);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_cur_delay", 32'(bus.cur_delay), 32'd0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    chk("rst_wraddr", 32'(bus.wraddr), 32'd0);
    drive(1'b0, 16'd0);
    chk("idle_wraddr", 32'(bus.wraddr), 32'd0);
    chk("idle_wren", 32'(bus.wren), 32'd0);

    // First fill with D=5 from IDLE, ramp starts at A+1
    bus.cfg_vld = 1'b1;
    bus.cfg_delay = 10'd5;
    drive(1'b0, 16'd0);
    bus.cfg_vld = 1'b0;
    ramp = 16'd0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        chk("t1_rdy_a1", 32'(bus.cfg_rdy), 32'd0);
        chk("t1_cur_delay", 32'(bus.cur_delay), 32'd5);
        chk("t1_wren", 32'(bus.wren), 32'd1);
      end
      if (k == 4) chk("t1_rdy_a4", 32'(bus.cfg_rdy), 32'd0);
      if (k == 5) begin
        chk("t1_rdy_a5", 32'(bus.cfg_rdy), 32'd1);
        chk("t1_rden_a5", 32'(bus.rden), 32'd1);
        chk("t1_out_vld_a5", 32'(bus.out_vld), 32'd0);
        chk("t1_rdaddr_a5", 32'(bus.rdaddr), 32'd0);
      end
      if (k == 6) begin
        chk("t1_out_vld_a6", 32'(bus.out_vld), 32'd1);
        chk("t1_out_data_a6", 32'(bus.out_data), 32'd0);
      end
      if (k == 9) chk("t1_out_data_a9", 32'(bus.out_data), 32'd3);
      drive_ramp();
    end
    run_stream("t1_lag5", 5, 20);

    // Long runs across many wptr wraps
    reconfig_run("t2_d2", 2, 5, 1100);
    reconfig_run("t2_d512", 512, 2, 1100);

    // Out-of-range requests in RUN
    reconfig_run("t3_d8", 8, 512, 30);
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      bus.cfg_vld = 1'b1;
      bus.cfg_delay = 10'(badv[j]);
      bad += stream_bad(8);
      drive_ramp();
      bus.cfg_vld = 1'b0;
      chk("t3_err_pulse", 32'(bus.cfg_err), 32'd1);
      chk("t3_cur_delay", 32'(bus.cur_delay), 32'd8);
      chk("t3_primed", 32'(bus.primed), 32'd1);
      bad += stream_bad(8);
      drive_ramp();
      chk("t3_err_clear", 32'(bus.cfg_err), 32'd0);
      bad += stream_bad(8);
      drive_ramp();
    end
    chk("t3_stream", 32'(bad), 32'd0);

    // Shrinking delay from RUN
    reconfig_run("t4_d10", 10, 8, 30);
    reconfig_run("t4_d4", 4, 10, 20);

    // Sparse valid pattern at D=3
    reconfig_run("t5_d3", 3, 4, 10);
    for (int k = 0; k < 8; k++) begin
      if (k >= 3) begin
        chk("t5_out_vld", 32'(bus.out_vld), 32'(pat_v[k-3]));
        if (pat_v[k-3]) chk("t5_out_data", 32'(bus.out_data), 32'(pat_d[k-3]));
      end
      if (k < 5) drive(pat_v[k], pat_d[k]);
      else drive(1'b0, 16'd0);
    end

    // Reset in the middle of RUN
    reconfig_run("t6_d6", 6, 3, 20);
    rst = 1'b1;
    drive_ramp();
    chk("t6_wren", 32'(bus.wren), 32'd0);
    chk("t6_rden", 32'(bus.rden), 32'd0);
    chk("t6_out_vld", 32'(bus.out_vld), 32'd0);
    chk("t6_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    chk("t6_wraddr", 32'(bus.wraddr), 32'd0);
    chk("t6_cur_delay", 32'(bus.cur_delay), 32'd0);
    chk("t6_primed", 32'(bus.primed), 32'd0);
    rst = 1'b0;
    drive_ramp();
    chk("t6_idle_wren", 32'(bus.wren), 32'd0);
    chk("t6_idle_wraddr", 32'(bus.wraddr), 32'd0);
    chk("t6_idle_out_vld", 32'(bus.out_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
